// File: rtl/ocimem_debug_arbiter_if.sv
// ----------------------------------------------------------------------------
// ocimem_debug_arbiter_if
// Avalon debug-slave bus between the CPU-side debug slave and the OCI memory
// arbiter.
//   av_address     word address into the OCI memory
//   av_read        read request (held until av_waitrequest is low)
//   av_write       write request (held until av_waitrequest is low)
//   av_writedata   write data
//   av_byteenable  byte lane enables
//   av_readdata    read data, valid in the cycle av_waitrequest drops
//   av_waitrequest stall back to the requester
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface ocimem_debug_arbiter_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] av_address;
    logic              av_read;
    logic              av_write;
    logic [31:0]       av_writedata;
    logic [3:0]        av_byteenable;
    logic [31:0]       av_readdata;
    logic              av_waitrequest;

    modport master (
        output av_address,
        output av_read,
        output av_write,
        output av_writedata,
        output av_byteenable,
        input  av_readdata,
        input  av_waitrequest
    );

    modport slave (
        input  av_address,
        input  av_read,
        input  av_write,
        input  av_writedata,
        input  av_byteenable,
        output av_readdata,
        output av_waitrequest
    );
endinterface

// File: rtl/ocimem_debug_arbiter.sv
// ----------------------------------------------------------------------------
// ocimem_debug_arbiter
// Shares the single-port OCI debug monitor RAM between the JTAG debug command
// path and the CPU-side Avalon debug slave. One RAM access is in flight at a
// time; the FSM returns to IDLE between accesses.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   jdo                   JTAG command/data word (valid with a strobe)
//   take_action_ocimem_a  load JTAG address from jdo[17+ADDR_W-1:17];
//                         jdo[34]=1 additionally queues a JTAG read
//   take_action_ocimem_b  queue a JTAG write of jdo[34:3]
//   av                    Avalon debug-slave bus (slave modport)
//   MonDReg               data returned by the last JTAG read
//   jt_busy               JTAG command pending or in service
//   jt_overrun            sticky: JTAG strobe arrived while jt_busy
//   ram_*                 registered RAM command; ram_rdata one cycle after
//                         ram_re
//
// Parameters:
//   ADDR_W      RAM word-address width
//   RAM_RD_LAT  RAM read latency; only 1 is supported
//
// Build option:
//   OCIMEM_JTAG_PRIORITY_EN  when defined, JTAG always wins a contested
//                            grant; otherwise grants alternate round-robin.
// ----------------------------------------------------------------------------
module ocimem_debug_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned RAM_RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [37:0]          jdo,
    input  logic                 take_action_ocimem_a,
    input  logic                 take_action_ocimem_b,
    ocimem_debug_arbiter_if.slave av,
    output logic [31:0]          MonDReg,
    output logic                 jt_busy,
    output logic                 jt_overrun,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [31:0]          ram_wdata,
    output logic [3:0]           ram_be,
    output logic                 ram_we,
    output logic                 ram_re,
    input  logic [31:0]          ram_rdata
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        AV_WR    = 3'd1,
        AV_RD    = 3'd2,
        AV_RDATA = 3'd3,
        JT_WR    = 3'd4,
        JT_RD    = 3'd5,
        JT_RDATA = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_next_s;

    logic [ADDR_W-1:0] jt_addr_r;
    logic [31:0]       jt_data_r;
    logic              jt_rd_r;
    logic              jt_pend_r;
    logic              jt_overrun_r;

    logic              av_done_r;
    logic [31:0]       av_readdata_r;
    logic [31:0]       mon_d_reg_r;

    logic [ADDR_W-1:0] ram_addr_r;
    logic [31:0]       ram_wdata_r;
    logic [3:0]        ram_be_r;
    logic              ram_we_r;
    logic              ram_re_r;

    logic              av_req_s;
    logic              jt_active_s;
    logic              jt_busy_s;
    logic              jt_strobe_s;
    logic              jt_accept_a_s;
    logic              jt_accept_b_s;
    logic              jt_addr_step_s;
    logic              pick_jt_s;
    logic              grant_av_s;
    logic              grant_jt_s;
    logic              rd_valid_s;
    logic              unused_jdo_s;

    // jdo carries fields this block never looks at
    assign unused_jdo_s = ^{jdo[37:35], jdo[2:0]};

    // The Avalon request is masked during its own completion cycle so a
    // held request is not accepted a second time.
    assign av_req_s       = (av.av_read | av.av_write) & ~av_done_r;
    assign jt_active_s    = (state_r == JT_WR) | (state_r == JT_RD) | (state_r == JT_RDATA);
    assign jt_busy_s      = jt_pend_r | jt_active_s;
    assign jt_strobe_s    = take_action_ocimem_a | take_action_ocimem_b;
    assign jt_accept_a_s  = take_action_ocimem_a & ~jt_busy_s;
    assign jt_accept_b_s  = take_action_ocimem_b & ~take_action_ocimem_a & ~jt_busy_s;
    assign jt_addr_step_s = (state_r == JT_WR) | (state_r == JT_RDATA);

`ifdef OCIMEM_JTAG_PRIORITY_EN
    assign pick_jt_s = 1'b1;
`else
    logic last_grant_jt_r;

    assign pick_jt_s = ~last_grant_jt_r;

    // Remember who was served last so a contested grant alternates
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_jt_r <= 1'b1;
        end else if (grant_av_s) begin
            last_grant_jt_r <= 1'b0;
        end else if (grant_jt_s) begin
            last_grant_jt_r <= 1'b1;
        end else begin
            last_grant_jt_r <= last_grant_jt_r;
        end
    end
`endif

    // Read data qualifier: RAM data is valid one clock after ram_re. Other
    // latencies are not supported, so reads would never return data.
    if (RAM_RD_LAT == 1) begin : g_rd_lat1
        logic rd_valid_r;

        // Delay ram_re to mark the cycle where ram_rdata is valid
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_valid_r <= 1'b0;
            end else begin
                rd_valid_r <= ram_re_r;
            end
        end

        assign rd_valid_s = rd_valid_r;
    end else begin : g_rd_lat_unsupported
        assign rd_valid_s = 1'b0;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and grant decision
    always_comb begin
        state_next_s = state_r;
        grant_av_s   = 1'b0;
        grant_jt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (av_req_s && jt_pend_r) begin
                    grant_jt_s = pick_jt_s;
                    grant_av_s = ~pick_jt_s;
                end else if (av_req_s) begin
                    grant_av_s = 1'b1;
                end else if (jt_pend_r) begin
                    grant_jt_s = 1'b1;
                end else begin
                    grant_av_s = 1'b0;
                    grant_jt_s = 1'b0;
                end

                if (grant_av_s) begin
                    state_next_s = av.av_write ? AV_WR : AV_RD;
                end else if (grant_jt_s) begin
                    state_next_s = jt_rd_r ? JT_RD : JT_WR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            AV_WR:    state_next_s = IDLE;
            AV_RD:    state_next_s = AV_RDATA;
            AV_RDATA: state_next_s = IDLE;
            JT_WR:    state_next_s = IDLE;
            JT_RD:    state_next_s = JT_RDATA;
            JT_RDATA: state_next_s = IDLE;
            default:  state_next_s = IDLE;
        endcase
    end

    // JTAG command capture, address auto-increment and overrun flag.
    // A strobe while busy is dropped; the address steps as the access
    // that used it finishes, so a step never coincides with a new load.
    always_ff @(posedge clk) begin
        if (reset) begin
            jt_addr_r    <= {ADDR_W{1'b0}};
            jt_data_r    <= 32'd0;
            jt_rd_r      <= 1'b0;
            jt_pend_r    <= 1'b0;
            jt_overrun_r <= 1'b0;
        end else begin
            if (jt_strobe_s && jt_busy_s) begin
                jt_overrun_r <= 1'b1;
            end

            if (jt_addr_step_s) begin
                jt_addr_r <= jt_addr_r + ADDR_W'(1);
                jt_pend_r <= 1'b0;
            end else if (jt_accept_a_s) begin
                jt_addr_r <= jdo[17 +: ADDR_W];
                if (jdo[34]) begin
                    jt_pend_r <= 1'b1;
                    jt_rd_r   <= 1'b1;
                end
            end else if (jt_accept_b_s) begin
                jt_pend_r <= 1'b1;
                jt_rd_r   <= 1'b0;
                jt_data_r <= jdo[34:3];
            end
        end
    end

    // RAM command registers; strobes follow the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= 32'd0;
            ram_be_r    <= 4'd0;
            ram_we_r    <= 1'b0;
            ram_re_r    <= 1'b0;
        end else begin
            ram_we_r <= (state_next_s == AV_WR) | (state_next_s == JT_WR);
            ram_re_r <= (state_next_s == AV_RD) | (state_next_s == JT_RD);
            if (grant_av_s) begin
                ram_addr_r  <= av.av_address;
                ram_wdata_r <= av.av_writedata;
                ram_be_r    <= av.av_byteenable;
            end else if (grant_jt_s) begin
                ram_addr_r  <= jt_addr_r;
                ram_wdata_r <= jt_data_r;
                ram_be_r    <= 4'hF;
            end
        end
    end

    // Avalon completion: done pulses in the write cycle, or in the cycle
    // after read data is captured
    always_ff @(posedge clk) begin
        if (reset) begin
            av_done_r     <= 1'b0;
            av_readdata_r <= 32'd0;
        end else begin
            av_done_r <= (state_next_s == AV_WR) | (state_r == AV_RDATA);
            if ((state_r == AV_RDATA) && rd_valid_s) begin
                av_readdata_r <= ram_rdata;
            end
        end
    end

    // JTAG read data return
    always_ff @(posedge clk) begin
        if (reset) begin
            mon_d_reg_r <= 32'd0;
        end else if ((state_r == JT_RDATA) && rd_valid_s) begin
            mon_d_reg_r <= ram_rdata;
        end else begin
            mon_d_reg_r <= mon_d_reg_r;
        end
    end

    assign av.av_waitrequest = (av.av_read | av.av_write) & ~av_done_r;
    assign av.av_readdata    = av_readdata_r;
    assign MonDReg           = mon_d_reg_r;
    assign jt_busy           = jt_busy_s;
    assign jt_overrun        = jt_overrun_r;
    assign ram_addr          = ram_addr_r;
    assign ram_wdata         = ram_wdata_r;
    assign ram_be            = ram_be_r;
    assign ram_we            = ram_we_r;
    assign ram_re            = ram_re_r;

endmodule

// File: tb/tb_ocimem_debug_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ocimem_debug_arbiter
// Self-checking bench for ocimem_debug_arbiter. A behavioural RAM sits on the
// ram_* port. Expected memory contents, JTAG address and read data come from
// a transaction-level model (an array plus the JTAG address pointer).
// Directed cases cover reset, Avalon/JTAG access timing, address wrap,
// contested grants, overrun and reset mid-read; a randomized phase mixes
// Avalon and JTAG traffic.
// ----------------------------------------------------------------------------
module tb_ocimem_debug_arbiter;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic [37:0]       jdo;
    logic              take_a;
    logic              take_b;
    logic [31:0]       mon_d_reg;
    logic              jt_busy;
    logic              jt_overrun;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       ram_rdata = 32'd0;

    ocimem_debug_arbiter_if #(.ADDR_W(ADDR_W)) av_bus ();

    ocimem_debug_arbiter #(.ADDR_W(ADDR_W), .RAM_RD_LAT(1)) dut (
        .clk                  (clk),
        .reset                (reset),
        .jdo                  (jdo),
        .take_action_ocimem_a (take_a),
        .take_action_ocimem_b (take_b),
        .av                   (av_bus),
        .MonDReg              (mon_d_reg),
        .jt_busy              (jt_busy),
        .jt_overrun           (jt_overrun),
        .ram_addr             (ram_addr),
        .ram_wdata            (ram_wdata),
        .ram_be               (ram_be),
        .ram_we               (ram_we),
        .ram_re               (ram_re),
        .ram_rdata            (ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency
    logic [31:0]       mem [0:DEPTH-1];
    int unsigned       wr_count     = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic [31:0]       last_wr_data = 32'd0;
    logic              both_seen    = 1'b0;

    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            wr_count     <= wr_count + 1;
            last_wr_addr <= ram_addr;
            last_wr_data <= ram_wdata;
        end
        if (ram_re) ram_rdata <= mem[ram_addr];
        if (ram_we && ram_re) both_seen <= 1'b1;
    end

    // Reference model state
    logic [31:0]       exp_mem [0:DEPTH-1];
    logic [ADDR_W-1:0] exp_jt_addr;
    int                n_checks = 0;
    int                n_errors = 0;
    logic [31:0]       rd_tmp;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [37:0] jdo_a(input logic [ADDR_W-1:0] addr, input logic rd);
        logic [37:0] j;
        j = {6'($urandom), 32'($urandom)};
        j[34] = rd;
        j[17 +: ADDR_W] = addr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] j;
        j = {6'($urandom), 32'($urandom)};
        j[34:3] = data;
        return j;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the Avalon transfer to complete, then release it
    task automatic av_wait(output logic [31:0] rdata);
        int cnt = 0;
        while (av_bus.av_waitrequest && cnt < 20) begin
            step();
            cnt++;
        end
        check_value("av_complete", 32'(av_bus.av_waitrequest), 32'd0);
        rdata = av_bus.av_readdata;
        step();
        av_bus.av_read  = 1'b0;
        av_bus.av_write = 1'b0;
    endtask

    task automatic av_write_op(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                               input logic [3:0] be);
        logic [31:0] dummy;
        av_bus.av_address    = addr;
        av_bus.av_writedata  = data;
        av_bus.av_byteenable = be;
        av_bus.av_write      = 1'b1;
        #1;
        av_wait(dummy);
        exp_mem[addr] = merge_be(exp_mem[addr], data, be);
    endtask

    task automatic av_read_op(input logic [ADDR_W-1:0] addr, output logic [31:0] data);
        av_bus.av_address    = addr;
        av_bus.av_byteenable = 4'hF;
        av_bus.av_read       = 1'b1;
        #1;
        av_wait(data);
    endtask

    task automatic jt_strobe_a(input logic [ADDR_W-1:0] addr, input logic rd);
        jdo    = jdo_a(addr, rd);
        take_a = 1'b1;
        step();
        take_a = 1'b0;
        exp_jt_addr = addr;
    endtask

    task automatic jt_strobe_b(input logic [31:0] data);
        jdo    = jdo_b(data);
        take_b = 1'b1;
        step();
        take_b = 1'b0;
    endtask

    task automatic wait_jt_idle();
        int cnt = 0;
        while (jt_busy && cnt < 12) begin
            step();
            cnt++;
        end
        check_value("jt_idle", 32'(jt_busy), 32'd0);
    endtask

    // Model of a completed JTAG write at the current JTAG address
    task automatic model_jt_write(input logic [31:0] data);
        exp_mem[exp_jt_addr] = data;
        exp_jt_addr          = exp_jt_addr + 8'd1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d1;
        logic [31:0] d2;
        logic [ADDR_W-1:0] a;
        int unsigned c0;
        logic [1:0] exp_grant;

        reset                = 1'b1;
        jdo                  = 38'd0;
        take_a               = 1'b0;
        take_b               = 1'b0;
        av_bus.av_address    = '0;
        av_bus.av_read       = 1'b0;
        av_bus.av_write      = 1'b0;
        av_bus.av_writedata  = 32'd0;
        av_bus.av_byteenable = 4'd0;
        exp_jt_addr          = '0;
        repeat (3) step();

        // Reset state
        check_value("rst_ctl", 32'({ram_we, ram_re, jt_busy, jt_overrun, av_bus.av_waitrequest}), 32'd0);
        check_value("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_value("rst_ram_wdata", ram_wdata, 32'd0);
        check_value("rst_ram_be", 32'(ram_be), 32'd0);
        check_value("rst_av_rdata", av_bus.av_readdata, 32'd0);
        check_value("rst_mondreg", mon_d_reg, 32'd0);
        reset = 1'b0;
        step();

        // Fill the RAM with known random contents
        for (int i = 0; i < DEPTH; i++) begin
            av_write_op(ADDR_W'(i), $urandom, 4'hF);
        end

        // Avalon write: RAM write in cycle 1, waitrequest low in cycle 1 only
        av_bus.av_address    = 8'h10;
        av_bus.av_writedata  = 32'hDEADBEEF;
        av_bus.av_byteenable = 4'b0011;
        av_bus.av_write      = 1'b1;
        #1;
        check_value("avw_wait_c0", 32'(av_bus.av_waitrequest), 32'd1);
        step();
        check_value("avw_ctl_c1", 32'({ram_we, ram_re, av_bus.av_waitrequest}), 32'b100);
        check_value("avw_addr_c1", 32'(ram_addr), 32'h10);
        check_value("avw_be_c1", 32'(ram_be), 32'b0011);
        check_value("avw_wdata_c1", ram_wdata, 32'hDEADBEEF);
        exp_mem[8'h10] = merge_be(exp_mem[8'h10], 32'hDEADBEEF, 4'b0011);
        step();
        check_value("avw_ctl_c2", 32'({ram_we, ram_re}), 32'd0);
        av_bus.av_write = 1'b0;
        check_value("avw_mem", mem[8'h10], exp_mem[8'h10]);

        // JTAG address-only load, then write
        jt_strobe_a(8'h20, 1'b0);
        check_value("jta_addr_only_busy", 32'(jt_busy), 32'd0);
        jdo    = jdo_b(32'h12345678);
        take_b = 1'b1;
        step();
        take_b = 1'b0;
        check_value("jtw_busy_t1", 32'(jt_busy), 32'd1);
        step();
        check_value("jtw_ctl_t2", 32'({ram_we, ram_re}), 32'b10);
        check_value("jtw_addr_t2", 32'(ram_addr), 32'h20);
        check_value("jtw_be_t2", 32'(ram_be), 32'hF);
        check_value("jtw_wdata_t2", ram_wdata, 32'h12345678);
        step();
        check_value("jtw_busy_t3", 32'(jt_busy), 32'd0);
        model_jt_write(32'h12345678);
        jt_strobe_b(32'h0BADF00D);
        wait_jt_idle();
        check_value("jtw_incr_addr", 32'(last_wr_addr), 32'(exp_jt_addr));
        model_jt_write(32'h0BADF00D);

        // JTAG read of a preloaded word
        av_write_op(8'h21, 32'hCAFEF00D, 4'hF);
        jt_strobe_a(8'h21, 1'b1);
        wait_jt_idle();
        check_value("jtr_mondreg", mon_d_reg, exp_mem[8'h21]);
        exp_jt_addr = exp_jt_addr + 8'd1;
        d1 = $urandom;
        jt_strobe_b(d1);
        wait_jt_idle();
        check_value("jtr_incr_addr", 32'(last_wr_addr), 32'(exp_jt_addr));
        model_jt_write(d1);

        // JTAG address wraps from the top word to zero
        jt_strobe_a(8'hFF, 1'b0);
        d1 = $urandom;
        jt_strobe_b(d1);
        wait_jt_idle();
        check_value("wrap_addr_ff", 32'(last_wr_addr), 32'hFF);
        model_jt_write(d1);
        d2 = $urandom;
        jt_strobe_b(d2);
        wait_jt_idle();
        check_value("wrap_addr_00", 32'(last_wr_addr), 32'h00);
        check_value("wrap_wdata", last_wr_data, d2);
        model_jt_write(d2);

        // Contested grant right after a JTAG grant
`ifdef OCIMEM_JTAG_PRIORITY_EN
        exp_grant = 2'b10;
`else
        exp_grant = 2'b01;
`endif
        d1     = $urandom;
        jdo    = jdo_b(d1);
        take_b = 1'b1;
        step();
        take_b               = 1'b0;
        av_bus.av_address    = 8'h40;
        av_bus.av_byteenable = 4'hF;
        av_bus.av_read       = 1'b1;
        step();
        check_value("contest_first", 32'({ram_we, ram_re}), 32'(exp_grant));
        av_wait(rd_tmp);
        check_value("contest_av_rdata", rd_tmp, exp_mem[8'h40]);
        wait_jt_idle();
        check_value("contest_jt_addr", 32'(last_wr_addr), 32'(exp_jt_addr));
        model_jt_write(d1);

        // Second strobe while busy is dropped and flagged
        c0     = wr_count;
        d1     = $urandom;
        d2     = $urandom;
        jdo    = jdo_b(d1);
        take_b = 1'b1;
        step();
        jdo = jdo_b(d2);
        step();
        take_b = 1'b0;
        wait_jt_idle();
        check_value("ovr_flag", 32'(jt_overrun), 32'd1);
        check_value("ovr_wr_count", wr_count - c0, 32'd1);
        check_value("ovr_wdata", last_wr_data, d1);
        model_jt_write(d1);

        // Reset during AV_RD aborts the read
        av_bus.av_address = 8'h05;
        av_bus.av_read    = 1'b1;
        #1;
        step();
        check_value("rstmid_re_c1", 32'(ram_re), 32'd1);
        reset          = 1'b1;
        av_bus.av_read = 1'b0;
        step();
        check_value("rstmid_ctl", 32'({ram_we, ram_re, jt_busy, jt_overrun, av_bus.av_waitrequest}), 32'd0);
        check_value("rstmid_ram_addr", 32'(ram_addr), 32'd0);
        check_value("rstmid_av_rdata", av_bus.av_readdata, 32'd0);
        check_value("rstmid_mondreg", mon_d_reg, 32'd0);
        step();
        reset = 1'b0;
        exp_jt_addr = '0;
        step();
        step();
        check_value("rstmid_no_complete", av_bus.av_readdata, 32'd0);

        // Randomized mixed traffic
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 5))
                0: av_write_op(ADDR_W'($urandom), $urandom, 4'($urandom));
                1: begin
                    a = ADDR_W'($urandom);
                    av_read_op(a, rd_tmp);
                    check_value("rnd_av_read", rd_tmp, exp_mem[a]);
                end
                2: begin
                    jt_strobe_a(ADDR_W'($urandom), 1'b0);
                    check_value("rnd_jt_addr_only", 32'(jt_busy), 32'd0);
                end
                3: begin
                    d1 = $urandom;
                    jt_strobe_b(d1);
                    wait_jt_idle();
                    check_value("rnd_jt_waddr", 32'(last_wr_addr), 32'(exp_jt_addr));
                    model_jt_write(d1);
                end
                4: begin
                    a = ADDR_W'($urandom);
                    jt_strobe_a(a, 1'b1);
                    wait_jt_idle();
                    check_value("rnd_jt_read", mon_d_reg, exp_mem[a]);
                    exp_jt_addr = a + 8'd1;
                end
                5: begin
                    a = ADDR_W'($urandom);
                    if (a == exp_jt_addr) a = a + 8'd1;
                    d1 = $urandom;
                    d2 = $urandom;
                    if ($urandom_range(0, 1) == 0) begin
                        fork
                            av_write_op(a, d2, 4'($urandom));
                            jt_strobe_b(d1);
                        join
                        wait_jt_idle();
                        model_jt_write(d1);
                    end else begin
                        fork
                            av_read_op(a, rd_tmp);
                            jt_strobe_b(d1);
                        join
                        wait_jt_idle();
                        check_value("rnd_conc_read", rd_tmp, exp_mem[a]);
                        model_jt_write(d1);
                    end
                end
                default: step();
            endcase
        end

        // Every model word must match the behavioural RAM
        c0 = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== exp_mem[i]) c0++;
        end
        check_value("final_mem_diffs", c0, 32'd0);
        check_value("final_no_we_re_overlap", 32'(both_seen), 32'd0);
        check_value("final_no_overrun", 32'(jt_overrun), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ocimem_debug_arbiter.md
Name: ocimem_debug_arbiter

Overview:
- Shares one single-port on-chip debug monitor RAM (OCI memory) between two requesters:
  - the JTAG debug command path (jdo bus plus take_action_ocimem_a/b strobes, already in the clk domain);
  - the CPU-side Avalon debug slave.
- Sequences RAM accesses, returns JTAG read data in MonDReg, stalls Avalon with waitrequest.
- Sits between the debug-slave sysclk stage and the monitor RAM inside the Nios II CPU debug module.

Parameters:
ADDR_W, 8, RAM word-address width (depth 2**ADDR_W x 32 bits)
RAM_RD_LAT, 1, RAM read latency in clocks; only value 1 supported

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
jdo  in  38  JTAG command/data word, valid in the cycle of a take_action strobe
take_action_ocimem_a  in  1  1-cycle strobe: load JTAG address = jdo[17+ADDR_W-1:17]; if jdo[34]=1, also queue a JTAG read
take_action_ocimem_b  in  1  1-cycle strobe: queue JTAG write of jdo[34:3] at JTAG address
av_address  in  ADDR_W  Avalon word address
av_read  in  1  Avalon read request
av_write  in  1  Avalon write request
av_writedata  in  32  Avalon write data
av_byteenable  in  4  Avalon byte enables
av_readdata  out  32  Avalon read data, registered
av_waitrequest  out  1  Avalon stall
MonDReg  out  32  last JTAG read data
jt_busy  out  1  JTAG request pending or in service
jt_overrun  out  1  sticky: a JTAG strobe arrived while jt_busy=1
ram_addr  out  ADDR_W  RAM address, registered
ram_wdata  out  32  RAM write data, registered
ram_be  out  4  RAM byte enables, registered
ram_we  out  1  RAM write enable, registered
ram_re  out  1  RAM read enable, registered
ram_rdata  in  32  RAM read data, valid 1 cycle after ram_re

Behaviour:
- Reset (sampled on a clk edge):
  - All outputs 0; state IDLE; JTAG address 0; pending cleared; last_grant = JTAG.
  - Reset mid-access aborts it: no Avalon completion, MonDReg not updated.
- av_waitrequest = (av_read | av_write) & ~av_done. av_done is a registered 1-cycle pulse; Avalon inputs must stay stable while waitrequest=1.
- JTAG capture:
  - A strobe in cycle T sets jt_pend at T+1 and latches the command (address, data, rd/wr).
  - If jt_busy=1 at T, the new command is dropped and jt_overrun set; cleared only by reset.
  - jt_busy = jt_pend | JTAG state active.
- States: IDLE, AV_WR, AV_RD, AV_RDATA, JT_WR, JT_RD, JT_RDATA.
- IDLE grant:
  - Only one requester pending → grant it.
  - Both pending → grant the one not equal to last_grant (round-robin); update last_grant on grant.
- Avalon write, accepted in cycle 0:
  - AV_WR in cycle 1: ram_we=1 with addr/data/be.
  - av_done=1 in cycle 1 (waitrequest low cycle 1); back to IDLE in cycle 2.
- Avalon read, accepted in cycle 0:
  - AV_RD cycle 1: ram_re=1.
  - AV_RDATA cycle 2: av_readdata <= ram_rdata.
  - av_done=1 in cycle 3 with av_readdata valid; IDLE cycle 3.
- JTAG write:
  - JT_WR: ram_we=1, ram_be=4'hF, data jdo[34:3] as latched.
  - JTAG address increments by 1 after the write, wrapping 2**ADDR_W-1 → 0; jt_pend cleared.
- JTAG read:
  - JT_RD: ram_re=1.
  - JT_RDATA: MonDReg <= ram_rdata.
  - JTAG address increments by 1 (wraps); jt_pend cleared.
- Address-only ocimem_a (jdo[34]=0):
  - Loads the address immediately at T+1.
  - No RAM access, jt_pend not set, no overrun check beyond jt_busy.
- Only one of ram_we/ram_re is ever high in a cycle; both are low in IDLE.
- A strobe coinciding with an Avalon grant is queued and served next per round-robin.
- Back-to-back: IDLE is revisited between accesses, so minimum spacing is 2 cycles (write) and 3 cycles (read).

Optional Feature:
- Macro: OCIMEM_JTAG_PRIORITY_EN.
- Defined: JTAG always wins when both requesters are pending; last_grant is ignored. An Avalon requester can starve while JTAG streams commands.
- Undefined: round-robin as above.

Test Plan:
- Avalon write 0xDEADBEEF, be=4'b0011, addr 0x10 → ram_we cycle 1 with be 0011; waitrequest low cycle 1 only.
- JTAG ocimem_a with addr 0x20, jdo[34]=0, then ocimem_b with data 0x12345678 → RAM write at 0x20, be=F; JTAG address becomes 0x21.
- RAM preloaded 0xCAFEF00D at 0x21; ocimem_a with addr 0x21, jdo[34]=1 → MonDReg=0xCAFEF00D within 3 cycles; jt_busy falls; address 0x22.
- JTAG write at addr 0xFF → address wraps to 0x00.
- Avalon read and JTAG write pending in the same cycle, last_grant=JTAG → Avalon served first, JTAG second. With OCIMEM_JTAG_PRIORITY_EN → JTAG first.
- Second ocimem_b strobe while jt_busy=1 → jt_overrun=1 and only one RAM write. Assert reset during AV_RD → no av_done, all outputs 0 next cycle.
